// File: rtl/inst_mem_pipe.sv
// RV32I fetch-stage instruction memory: registered read with valid/ready back-pressure,
// byte-enabled write port, fault flagging and a reset-time clear sequencer.
module inst_mem_pipe #(
  parameter int          DEPTH     = 64,
  parameter int          IDX_W     = $clog2(DEPTH),
  parameter              INIT_FILE = "",
  parameter logic [31:0] NOP       = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_stall,
  output logic [31:0] rsp_data,
  output logic        rsp_fault,
  input  logic        wb_en,
  input  logic [3:0]  wb_be,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_data,
  output logic        init_done
);

  localparam bit               USE_FILE = (INIT_FILE != "");
  localparam logic [29:0]      DEPTH_W  = 30'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_clr_cnt;
  logic [IDX_W-1:0] w_clr_cnt_nxt;
  logic             w_clr_we;

  logic [31:0]      r_mem [DEPTH];

  logic             r_rsp_valid;
  logic [31:0]      r_rsp_data;
  logic             r_rsp_fault;

  logic             w_req_inr;
  logic             w_req_fault;
  logic             w_accept;
  logic [IDX_W-1:0] w_ridx;
  logic [31:0]      w_rd_word;

  logic             w_wb_inr;
  logic             w_wb_we;
  logic [IDX_W-1:0] w_widx;
  logic [31:0]      w_wb_word;
  logic             w_unused_wb_low;

  assign w_unused_wb_low = ^wb_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= USE_FILE ? S_RUN : S_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_clr_we      = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr_we = !rst;
        if (r_clr_cnt == LAST_IDX) begin
          w_state_nxt = S_RUN;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        end
      end
      S_RUN: begin
        w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_CLEAR;
      end
    endcase
  end

  assign init_done = (r_state == S_RUN);
  assign req_ready = init_done && (!r_rsp_valid || !rsp_stall);
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    w_req_inr   = (req_addr[31:2] < DEPTH_W);
    w_req_fault = (req_addr[1:0] != 2'b00) || !w_req_inr;
    w_ridx      = w_req_inr ? req_addr[IDX_W+1:2] : '0;

    w_wb_inr    = (wb_addr[31:2] < DEPTH_W);
    w_widx      = w_wb_inr ? wb_addr[IDX_W+1:2] : '0;
    w_wb_we     = (r_state == S_RUN) && wb_en && w_wb_inr && !rst;
  end

  // Write merge and write-first read bypass, byte by byte.
  always_comb begin
    w_wb_word = r_mem[w_widx];
    w_rd_word = r_mem[w_ridx];
    for (int unsigned i = 0; i < 4; i++) begin
      if (wb_be[i]) begin
        w_wb_word[8*i +: 8] = wb_data[8*i +: 8];
        if (w_wb_we && (w_widx == w_ridx)) begin
          w_rd_word[8*i +: 8] = wb_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= NOP;
    end else if (w_wb_we) begin
      r_mem[w_widx] <= w_wb_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= NOP;
      r_rsp_fault <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_req_fault ? NOP : w_rd_word;
      r_rsp_fault <= w_req_fault;
    end else if (!(r_rsp_valid && rsp_stall)) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_fault = r_rsp_fault;

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Scoreboard bench for inst_mem_pipe (DEPTH=8, cleared to NOP): directed fetch/write
// vectors push expected responses; a negedge monitor pops them as responses are consumed.
module tb_inst_mem_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_stall;
    logic [31:0] rsp_data;
    logic        rsp_fault;
    logic        wb_en;
    logic [3:0]  wb_be;
    logic [31:0] wb_addr;
    logic [31:0] wb_data;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] d;
        logic        f;
    } exp_t;
    exp_t sb[$];

    inst_mem_pipe #(
        .DEPTH    (8),
        .INIT_FILE("")
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .rsp_valid(rsp_valid),
        .rsp_stall(rsp_stall),
        .rsp_data (rsp_data),
        .rsp_fault(rsp_fault),
        .wb_en    (wb_en),
        .wb_be    (wb_be),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a response is consumed at the next posedge when valid and not stalled.
    always @(negedge clk) begin
        if (!rst && rsp_valid && !rsp_stall) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got data %h fault %b, none expected", rsp_data, rsp_fault);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rsp_data !== e.d || rsp_fault !== e.f) begin
                    errors++;
                    $display("FAIL rsp: got data %h fault %b expected data %h fault %b",
                             rsp_data, rsp_fault, e.d, e.f);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic f);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: addr %h never accepted, req_ready %b expected 1", a, req_ready);
        end else begin
            sb.push_back('{d, f});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_be   = be;
        wb_data = d;
        @(posedge clk);
        #1;
        wb_en = 1'b0;
    endtask

    // Counts posedges after reset release until init_done; optionally pokes a write mid-clear.
    task automatic wait_init(input string name, input bit poke);
        int n;
        n = 0;
        while (!init_done && n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (poke && n == 2) begin
                wb_en = 1'b1; wb_addr = 32'h0; wb_be = 4'hF; wb_data = 32'hFFFFFFFF;
            end
            if (poke && n == 3) wb_en = 1'b0;
            @(negedge clk);
        end
        wb_en = 1'b0;
        check(name, n, 8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_stall = 1'b0;
        wb_en = 1'b0; wb_be = '0; wb_addr = '0; wb_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        check("rst_rsp_data",  rsp_data, 32'h00000013);
        check("rst_rsp_fault", {31'b0, rsp_fault}, 0);
        check("rst_init_done", {31'b0, init_done}, 0);
        check("rst_req_ready", {31'b0, req_ready}, 0);

        // 1: clear takes exactly DEPTH cycles, all words NOP
        rst = 1'b0;
        wait_init("clear_cycles", 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) issue(32'(4 * i), 32'h00000013, 1'b0);

        // 2: full-word write then fetch
        write(32'h4, 4'hF, 32'hDEADBEEF);
        issue(32'h4, 32'hDEADBEEF, 1'b0);

        // 3: same-cycle partial write and fetch returns merged word
        write(32'h8, 4'hF, 32'h11223344);
        fork
            write(32'h8, 4'h1, 32'h000000AA);
            issue(32'h8, 32'h112233AA, 1'b0);
        join
        issue(32'h8, 32'h112233AA, 1'b0);

        // 4: faults, out-of-range write dropped, be=0 no-op, last word
        issue(32'h6,  32'h00000013, 1'b1);
        issue(32'h20, 32'h00000013, 1'b1);
        write(32'h20, 4'hF, 32'hFFFFFFFF);
        issue(32'h0,  32'h00000013, 1'b0);
        write(32'h4, 4'h0, 32'h12345678);
        issue(32'h4,  32'hDEADBEEF, 1'b0);
        write(32'h1C, 4'hC, 32'hABCD0000);
        issue(32'h1C, 32'hABCD0013, 1'b0);

        // 5: back-to-back with a 3-cycle stall on the second response
        fork
            begin
                issue(32'h0, 32'h00000013, 1'b0);
                issue(32'h4, 32'hDEADBEEF, 1'b0);
                issue(32'h8, 32'h112233AA, 1'b0);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                rsp_stall = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("stall_ready", {31'b0, req_ready}, 0);
                    check("stall_valid", {31'b0, rsp_valid}, 1);
                    check("stall_hold",  rsp_data, 32'hDEADBEEF);
                    @(posedge clk);
                    #1;
                end
                rsp_stall = 1'b0;
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // 6: reset discards an in-flight response, then reset in mid-clear restarts it
        rsp_stall = 1'b1;
        issue(32'h1C, 32'hABCD0013, 1'b0);
        check("inflight_valid", {31'b0, rsp_valid}, 1);
        rst = 1'b1;
        #1;
        check("rst_drops_valid", {31'b0, rsp_valid}, 0);
        sb.delete();
        rsp_stall = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midclear_init", {31'b0, init_done}, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_init("reclear_cycles", 1'b1);
        @(posedge clk); #1;
        issue(32'h0,  32'h00000013, 1'b0);
        issue(32'h4,  32'h00000013, 1'b0);
        issue(32'h8,  32'h00000013, 1'b0);
        issue(32'h1C, 32'h00000013, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
